// File: rtl/traffic_violation_logger.sv
// Timestamped camera-trigger logger: edge-detects violation strobes, applies a
// re-trigger holdoff, and queues {timestamp, ID, state} records in a FWFT FIFO.
module traffic_violation_logger #(
  parameter int DEPTH   = 8,
  parameter int TS_W    = 16,
  parameter int HOLDOFF = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     camera,
  input  logic [11:0]              ID,
  input  logic [5:0]               state,
  input  logic                     flush,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_ts,
  output logic [11:0]              rd_id,
  output logic [5:0]               rd_state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int REC_W = TS_W + 18;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             cam_q;
  logic [HW-1:0]    hold_q, hold_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic trig, acc, full, pop, push, drop;

  // A trigger inside the holdoff window is invisible: it neither stores nor
  // counts as a drop, and it does not restart the window.
  assign trig = camera & ~cam_q;
  assign acc  = trig & (hold_q == '0);
  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) & rd_ready & ~flush;
  assign push = acc & ~flush & (~full | pop);
  assign drop = acc & ~flush & full & ~pop;

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (acc)
      hold_d = HOLD_LD;
    else if (hold_q != '0)
      hold_d = hold_q - HW'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF)
          drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ts_q     <= '0;
      cam_q    <= 1'b0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      cam_q    <= camera;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Record storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= {ts_q, ID, state};
  end

  assign rd_valid   = (count_q != '0);
  assign rd_ts      = rd_valid ? mem_q[rd_ptr_q][REC_W-1:18] : '0;
  assign rd_id      = rd_valid ? mem_q[rd_ptr_q][17:6]       : '0;
  assign rd_state   = rd_valid ? mem_q[rd_ptr_q][5:0]        : '0;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
